// File: rtl/key_debounce.sv
// Key debouncer: two-flop synchronizer followed by a four-state filter FSM.
// A new level is accepted only after it holds for CNT_MAX consecutive cycles.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// STABLE_LO  | debounced level is 0, waiting for key_s = 1
// FILT_HI    | key_s went high, counting toward acceptance of level 1
// STABLE_HI  | debounced level is 1, waiting for key_s = 0
// FILT_LO    | key_s went low, counting toward acceptance of level 0
module key_debounce #(
   parameter int   CNT_MAX    = 1000000,
   parameter logic INIT_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic glitch
);

   localparam int             CW       = $clog2(CNT_MAX);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      FILT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      FILT_LO   = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            sync1;
   logic            sync2;
   logic            key_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= INIT_LEVEL;
         sync2 <= INIT_LEVEL;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   assign key_s = sync2;

   // cnt is only meaningful inside FILT states; it is cleared on every entry
   // and stops at CNT_LAST because acceptance leaves the FILT state there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
         cnt         <= '0;
         key_level   <= INIT_LEVEL;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         glitch      <= 1'b0;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         glitch      <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (key_s) begin
                  state <= FILT_HI;
                  cnt   <= '0;
               end
            end
            FILT_HI: begin
               if (!key_s) begin
                  state  <= STABLE_LO;
                  glitch <= 1'b1;
               end else if (cnt == CNT_LAST) begin
                  state     <= STABLE_HI;
                  key_level <= 1'b1;
                  key_press <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE_HI: begin
               if (!key_s) begin
                  state <= FILT_LO;
                  cnt   <= '0;
               end
            end
            FILT_LO: begin
               if (key_s) begin
                  state  <= STABLE_HI;
                  glitch <= 1'b1;
               end else if (cnt == CNT_LAST) begin
                  state       <= STABLE_LO;
                  key_level   <= 1'b0;
                  key_release <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (CNT_MAX = 4): directed literal scenarios plus a
// random-bounce soak, all checked every cycle against a run-length model.
module tb_key_debounce;

   localparam int CM = 4;

   logic clk = 1'b0;
   logic rst;
   logic key_in;
   logic key_level;
   logic key_press;
   logic key_release;
   logic glitch;

   int tests = 0;
   int fails = 0;

   key_debounce #(.CNT_MAX(CM), .INIT_LEVEL(1'b0)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .glitch      (glitch)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: key_s is key_in seen two edges late; a level is accepted once
   // key_s has disagreed with the current level for CM+1 consecutive edges,
   // and a run broken early is a glitch.
   logic m_level, m_press, m_rel, m_glitch, m_h1, m_h2, m_ks;
   int   m_run;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_glitch = 1'b0;
         m_h1 = 1'b0; m_h2 = 1'b0; m_run = 0;
      end else begin
         m_ks = m_h2;
         m_h2 = m_h1;
         m_h1 = key_in;
         m_press = 1'b0; m_rel = 1'b0; m_glitch = 1'b0;
         if (m_ks != m_level) begin
            m_run++;
            if (m_run == CM + 1) begin
               m_level = m_ks;
               m_press = m_ks;
               m_rel   = !m_ks;
               m_run   = 0;
            end
         end else if (m_run > 0) begin
            m_glitch = 1'b1;
            m_run    = 0;
         end
      end
   end

   int last_pulse = 2;   // 1 = press, 2 = release
   always @(negedge clk) begin
      check("level", key_level, m_level);
      check("press", key_press, m_press);
      check("release", key_release, m_rel);
      check("glitch", glitch, m_glitch);
      if (rst) last_pulse = 2;
      if (key_press) begin
         check("press_alternates", logic'(last_pulse == 2), 1'b1);
         last_pulse = 1;
      end
      if (key_release) begin
         check("release_alternates", logic'(last_pulse == 1), 1'b1);
         last_pulse = 2;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int hold;

   initial begin
      rst = 1'b1;
      key_in = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("reset_level", key_level, 1'b0);
      check("reset_press", key_press, 1'b0);
      check("reset_release", key_release, 1'b0);
      check("reset_glitch", glitch, 1'b0);
      repeat (3) step();

      // clean press: accepted on edge N+6
      key_in = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         step();
         check("clean_level", key_level, logic'(i >= 6));
         check("clean_press", key_press, logic'(i == 6));
         check("clean_glitch", glitch, 1'b0);
      end

      // release from STABLE_HI
      key_in = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         step();
         check("rel_level", key_level, logic'(i < 6));
         check("rel_release", key_release, logic'(i == 6));
      end

      // bounce: 1 for 3 samples, 0 for 1, then held high
      key_in = 1'b1;
      for (int i = 0; i <= 11; i++) begin
         step();
         check("bounce_glitch", glitch, logic'(i == 5));
         check("bounce_press", key_press, logic'(i == 10));
         check("bounce_level", key_level, logic'(i >= 10));
         if (i == 2) key_in = 1'b0;
         if (i == 3) key_in = 1'b1;
      end
      key_in = 1'b0;
      repeat (10) step();

      // late abort: key_s drops while cnt = CM-1
      key_in = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         step();
         check("late_glitch", glitch, logic'(i == 6));
         check("late_level", key_level, 1'b0);
         check("late_press", key_press, 1'b0);
         if (i == 3) key_in = 1'b0;
      end
      repeat (3) step();

      // reset mid-filter with cnt = 2, key still held
      key_in = 1'b1;
      for (int i = 0; i <= 4; i++) step();
      #1 rst = 1'b1;
      #1;
      check("midrst_level", key_level, 1'b0);
      check("midrst_press", key_press, 1'b0);
      check("midrst_glitch", glitch, 1'b0);
      step();
      step();
      #1 rst = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         step();
         check("postrst_press", key_press, logic'(i == 6));
         check("postrst_level", key_level, logic'(i >= 6));
      end
      key_in = 1'b0;
      repeat (10) step();

      // random-bounce soak
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         step();
         if (hold == 0) begin
            key_in = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15))
                                                : int'($urandom_range(0, 4));
         end else begin
            hold--;
         end
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
      end

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
